// File: rtl/avalon_st_error_adapter_reg.sv
// rtl/avalon_st_error_adapter_reg.sv - Registered Avalon-ST error adapter with skid buffer and errored-beat counter
// Reduces a masked multi-bit sink error to one bit, per beat or packet-sticky on EOP.
module avalon_st_error_adapter_reg #(
  parameter int                   DATA_W   = 32,
  parameter int                   EMPTY_W  = 2,
  parameter int                   IN_ERR_W = 6,
  parameter logic [IN_ERR_W-1:0]  ERR_MASK = {IN_ERR_W{1'b1}},
  parameter int                   MODE     = 0,
  parameter int                   CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               in_ready,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [IN_ERR_W-1:0] in_error,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_error,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  input  logic               cnt_clear,
  output logic [CNT_W-1:0]   err_count
);

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_error;
  logic               r_out_sop;
  logic               r_out_eop;
  logic [EMPTY_W-1:0] r_out_empty;

  logic               r_skid_valid;
  logic [DATA_W-1:0]  r_skid_data;
  logic               r_skid_error;
  logic               r_skid_sop;
  logic               r_skid_eop;
  logic [EMPTY_W-1:0] r_skid_empty;

  logic               r_acc;
  logic [CNT_W-1:0]   r_err_count;

  logic w_in_accept;
  logic w_out_load;
  logic w_e;
  logic w_acc_next;
  logic w_beat_err;

  assign w_in_accept = in_valid & ~r_skid_valid;
  assign w_out_load  = ~r_out_valid | out_ready;
  assign w_e         = |(in_error & ERR_MASK);

  // Packet-sticky mode folds errors into r_acc and reports only on the EOP beat.
  always_comb begin
    w_acc_next = (in_startofpacket ? 1'b0 : r_acc) | w_e;
    w_beat_err = w_e;
    if (MODE == 1) begin
      w_beat_err = in_endofpacket ? w_acc_next : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= 1'b0;
    end else if (w_in_accept) begin
      r_acc <= in_endofpacket ? 1'b0 : w_acc_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_error  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
      r_out_empty  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_error <= 1'b0;
      r_skid_sop   <= 1'b0;
      r_skid_eop   <= 1'b0;
      r_skid_empty <= '0;
    end else if (w_out_load) begin
      r_skid_valid <= 1'b0;
      if (r_skid_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_skid_data;
        r_out_error <= r_skid_error;
        r_out_sop   <= r_skid_sop;
        r_out_eop   <= r_skid_eop;
        r_out_empty <= r_skid_empty;
      end else if (w_in_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data;
        r_out_error <= w_beat_err;
        r_out_sop   <= in_startofpacket;
        r_out_eop   <= in_endofpacket;
        r_out_empty <= in_empty;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_accept) begin
      // Output is stalled: park the beat accepted this cycle in the skid slot.
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
      r_skid_error <= w_beat_err;
      r_skid_sop   <= in_startofpacket;
      r_skid_eop   <= in_endofpacket;
      r_skid_empty <= in_empty;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= '0;
    end else if (cnt_clear) begin
      r_err_count <= '0;
    end else if (r_out_valid && out_ready && r_out_error && (r_err_count != {CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign in_ready          = ~r_skid_valid;
  assign out_valid         = r_out_valid;
  assign out_data          = r_out_data;
  assign out_error         = r_out_error;
  assign out_startofpacket = r_out_sop;
  assign out_endofpacket   = r_out_eop;
  assign out_empty         = r_out_empty;
  assign err_count         = r_err_count;

endmodule

// File: tb/tb_avalon_st_error_adapter_reg.sv
// tb/tb_avalon_st_error_adapter_reg.sv - Directed self-checking bench for avalon_st_error_adapter_reg
// Four instances (per-beat, packet-sticky, narrow mask, 2-bit counter) share one input stream.
module tb_avalon_st_error_adapter_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, sop, eop, out_ready, cnt_clear;
  logic [31:0] in_data;
  logic [5:0]  in_error;
  logic [1:0]  in_empty;

  logic        a_ir, a_ov, a_oe, a_os, a_oq;  logic [31:0] a_od; logic [1:0] a_em; logic [15:0] a_cnt;
  logic        b_ir, b_ov, b_oe, b_os, b_oq;  logic [31:0] b_od; logic [1:0] b_em; logic [15:0] b_cnt;
  logic        m_ir, m_ov, m_oe, m_os, m_oq;  logic [31:0] m_od; logic [1:0] m_em; logic [15:0] m_cnt;
  logic        c_ir, c_ov, c_oe, c_os, c_oq;  logic [31:0] c_od; logic [1:0] c_em; logic [1:0]  c_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  avalon_st_error_adapter_reg u_m0 (
    .clk(clk), .reset_n(reset_n), .in_ready(a_ir), .in_valid(in_valid), .in_data(in_data),
    .in_error(in_error), .in_startofpacket(sop), .in_endofpacket(eop), .in_empty(in_empty),
    .out_ready(out_ready), .out_valid(a_ov), .out_data(a_od), .out_error(a_oe),
    .out_startofpacket(a_os), .out_endofpacket(a_oq), .out_empty(a_em),
    .cnt_clear(cnt_clear), .err_count(a_cnt));

  avalon_st_error_adapter_reg #(.MODE(1)) u_m1 (
    .clk(clk), .reset_n(reset_n), .in_ready(b_ir), .in_valid(in_valid), .in_data(in_data),
    .in_error(in_error), .in_startofpacket(sop), .in_endofpacket(eop), .in_empty(in_empty),
    .out_ready(out_ready), .out_valid(b_ov), .out_data(b_od), .out_error(b_oe),
    .out_startofpacket(b_os), .out_endofpacket(b_oq), .out_empty(b_em),
    .cnt_clear(cnt_clear), .err_count(b_cnt));

  avalon_st_error_adapter_reg #(.ERR_MASK(6'h01)) u_mk (
    .clk(clk), .reset_n(reset_n), .in_ready(m_ir), .in_valid(in_valid), .in_data(in_data),
    .in_error(in_error), .in_startofpacket(sop), .in_endofpacket(eop), .in_empty(in_empty),
    .out_ready(out_ready), .out_valid(m_ov), .out_data(m_od), .out_error(m_oe),
    .out_startofpacket(m_os), .out_endofpacket(m_oq), .out_empty(m_em),
    .cnt_clear(cnt_clear), .err_count(m_cnt));

  avalon_st_error_adapter_reg #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset_n(reset_n), .in_ready(c_ir), .in_valid(in_valid), .in_data(in_data),
    .in_error(in_error), .in_startofpacket(sop), .in_endofpacket(eop), .in_empty(in_empty),
    .out_ready(out_ready), .out_valid(c_ov), .out_data(c_od), .out_error(c_oe),
    .out_startofpacket(c_os), .out_endofpacket(c_oq), .out_empty(c_em),
    .cnt_clear(cnt_clear), .err_count(c_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [5:0] e,
                       input logic s, input logic q);
    in_valid = v; in_data = d; in_error = e; sop = s; eop = q; in_empty = d[1:0];
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; cnt_clear = 1'b0; out_ready = 1'b1;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    #2;
    chk("rst_out_valid", a_ov, 1'b0);
    chk("rst_in_ready", a_ir, 1'b1);
    chk("rst_out_data", a_od, 32'h0);
    chk("rst_err_count", a_cnt, 16'h0);
    #1 reset_n = 1'b1;
    tick();

    // Streaming, per-beat mode
    drive(1'b1, 32'h11, 6'h00, 1'b1, 1'b0); tick();
    chk("s1_valid", a_ov, 1'b1); chk("s1_data", a_od, 32'h11); chk("s1_err", a_oe, 1'b0);
    chk("s1_sop", a_os, 1'b1); chk("s1_empty", a_em, 2'h1);
    drive(1'b1, 32'h22, 6'h00, 1'b0, 1'b0); tick();
    chk("s2_data", a_od, 32'h22); chk("s2_err", a_oe, 1'b0);
    drive(1'b1, 32'h33, 6'h04, 1'b0, 1'b0); tick();
    chk("s3_data", a_od, 32'h33); chk("s3_err", a_oe, 1'b1); chk("s3_mask_err", m_oe, 1'b0);
    drive(1'b1, 32'h44, 6'h00, 1'b0, 1'b1); tick();
    chk("s4_data", a_od, 32'h44); chk("s4_err", a_oe, 1'b0); chk("s4_eop", a_oq, 1'b1);
    chk("s4_cnt", a_cnt, 16'h1);
    drive(1'b0, 32'h0, 6'h00, 1'b0, 1'b0); tick();
    chk("s5_idle_valid", a_ov, 1'b0); chk("s5_cnt", a_cnt, 16'h1);

    // Backpressure with skid absorption
    do_reset();
    drive(1'b1, 32'hA0, 6'h00, 1'b0, 1'b0); tick();
    chk("bp0_data", a_od, 32'hA0);
    out_ready = 1'b0;
    drive(1'b1, 32'hA1, 6'h00, 1'b0, 1'b0); tick();
    chk("bp1_in_ready", a_ir, 1'b0); chk("bp1_data", a_od, 32'hA0); chk("bp1_valid", a_ov, 1'b1);
    drive(1'b1, 32'hA2, 6'h00, 1'b0, 1'b0); tick();
    chk("bp2_data", a_od, 32'hA0); chk("bp2_in_ready", a_ir, 1'b0);
    tick();
    chk("bp3_data", a_od, 32'hA0); chk("bp3_in_ready", a_ir, 1'b0);
    out_ready = 1'b1; tick();
    chk("bp4_data", a_od, 32'hA1); chk("bp4_in_ready", a_ir, 1'b1);
    tick();
    chk("bp5_data", a_od, 32'hA2);
    drive(1'b1, 32'hA3, 6'h00, 1'b0, 1'b0); tick();
    chk("bp6_data", a_od, 32'hA3);
    drive(1'b0, 32'h0, 6'h00, 1'b0, 1'b0); tick();
    chk("bp7_valid", a_ov, 1'b0);

    // Packet-sticky mode
    do_reset();
    drive(1'b1, 32'hB1, 6'h00, 1'b1, 1'b0); tick(); chk("p1_err", b_oe, 1'b0);
    drive(1'b1, 32'hB2, 6'h20, 1'b0, 1'b0); tick(); chk("p2_err", b_oe, 1'b0);
    chk("p2_m0_err", a_oe, 1'b1);
    drive(1'b1, 32'hB3, 6'h00, 1'b0, 1'b0); tick(); chk("p3_err", b_oe, 1'b0);
    drive(1'b1, 32'hB4, 6'h00, 1'b0, 1'b0); tick(); chk("p4_err", b_oe, 1'b0);
    drive(1'b1, 32'hB5, 6'h00, 1'b0, 1'b1); tick();
    chk("p5_err", b_oe, 1'b1); chk("p5_eop", b_oq, 1'b1);
    drive(1'b1, 32'hC1, 6'h00, 1'b1, 1'b0); tick(); chk("q1_err", b_oe, 1'b0);
    chk("q1_cnt", b_cnt, 16'h1);
    drive(1'b1, 32'hC2, 6'h00, 1'b0, 1'b1); tick(); chk("q2_err", b_oe, 1'b0);
    drive(1'b1, 32'hC3, 6'h01, 1'b1, 1'b1); tick(); chk("single_err", b_oe, 1'b1);
    drive(1'b0, 32'h0, 6'h00, 1'b0, 1'b0); tick(); chk("p_cnt", b_cnt, 16'h2);

    // Error mask
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hD0 + i, 6'h3E, 1'b0, 1'b0); tick();
      chk("mask_hidden_err", m_oe, 1'b0);
    end
    drive(1'b1, 32'hD3, 6'h01, 1'b0, 1'b0); tick();
    chk("mask_cnt0", m_cnt, 16'h0); chk("mask_bit_err", m_oe, 1'b1);
    drive(1'b0, 32'h0, 6'h00, 1'b0, 1'b0); tick();
    chk("mask_cnt1", m_cnt, 16'h1);

    // Saturating counter and clear priority
    do_reset();
    drive(1'b1, 32'hE0, 6'h01, 1'b0, 1'b0); tick();
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) drive(1'b0, 32'h0, 6'h00, 1'b0, 1'b0);
      else        drive(1'b1, 32'hE0 + i, 6'h01, 1'b0, 1'b0);
      tick();
      chk("sat_cnt", c_cnt, (i < 3) ? 2'(i) : 2'd3);
    end
    drive(1'b1, 32'hEF, 6'h01, 1'b0, 1'b0); tick();
    chk("pre_clear_cnt", c_cnt, 2'd3); chk("pre_clear_err", c_oe, 1'b1);
    drive(1'b0, 32'h0, 6'h00, 1'b0, 1'b0); cnt_clear = 1'b1; tick();
    chk("clear_prio_cnt", c_cnt, 2'd0);
    cnt_clear = 1'b0;

    // Reset mid-packet with skid full and accumulator set
    do_reset();
    drive(1'b1, 32'hF1, 6'h20, 1'b1, 1'b0); tick();
    out_ready = 1'b0;
    drive(1'b1, 32'hF2, 6'h00, 1'b0, 1'b0); tick();
    chk("mid_skid_full", b_ir, 1'b0);
    reset_n = 1'b0; #1;
    chk("mid_rst_valid", b_ov, 1'b0); chk("mid_rst_in_ready", b_ir, 1'b1);
    #2 reset_n = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'hF3, 6'h00, 1'b0, 1'b1); tick();
    chk("post_rst_frag_err", b_oe, 1'b0);
    drive(1'b1, 32'hF4, 6'h00, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hF5, 6'h00, 1'b0, 1'b1); tick();
    chk("post_rst_pkt_err", b_oe, 1'b0); chk("post_rst_pkt_data", b_od, 32'hF5);
    drive(1'b0, 32'h0, 6'h00, 1'b0, 1'b0); tick();
    chk("post_rst_cnt", b_cnt, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
